// File: rtl/cards_hit_detect.sv
// cards_hit_detect: loads card positions from the generator and answers mouse hit tests by scanning one card per cycle.
module cards_hit_detect #(
    parameter int CARD_W        = 200,
    parameter int CARD_H_EASY   = 300,
    parameter int CARD_H_NORMAL = 200,
    parameter int CARD_H_HARD   = 150
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_positions,
    input  logic [4:0]  num_of_cards,
    input  logic [19:0] yx_card_position,
    output logic        read_all_positions,
    input  logic [9:0]  mouse_xpos,
    input  logic [9:0]  mouse_ypos,
    input  logic        mouse_click,
    output logic        positions_valid,
    output logic        busy,
    output logic        hit_done,
    output logic        hit_found,
    output logic [4:0]  hit_index
);
    localparam logic [4:0] CARD_NUM_EASY   = 5'd8;
    localparam logic [4:0] CARD_NUM_NORMAL = 5'd12;
    localparam logic [4:0] CARD_NUM_HARD   = 5'd16;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPTURE, SCAN} state_t;

    state_t      state, state_n;
    logic [4:0]  n;
    logic [3:0]  idx;
    logic [9:0]  mx, my;
    logic [19:0] tbl [16];
    logic [19:0] e;
    logic [10:0] h, x_end, y_end;
    logic        load_ok, last, hit;

    assign load_ok = load_positions && (num_of_cards == CARD_NUM_EASY ||
                     num_of_cards == CARD_NUM_NORMAL || num_of_cards == CARD_NUM_HARD);
    assign last  = {1'b0, idx} == n - 5'd1;
    assign e     = tbl[idx];
    assign h     = n == CARD_NUM_EASY ? 11'(CARD_H_EASY) :
                   n == CARD_NUM_NORMAL ? 11'(CARD_H_NORMAL) : 11'(CARD_H_HARD);
    // 11-bit sums so a card near the screen edge cannot wrap around
    assign x_end = {1'b0, e[9:0]} + 11'(CARD_W);
    assign y_end = {1'b0, e[19:10]} + h;
    assign hit   = ~&e && mx >= e[9:0] && {1'b0, mx} < x_end &&
                   my >= e[19:10] && {1'b0, my} < y_end;
    assign busy  = state != IDLE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = load_ok ? REQ : (mouse_click && positions_valid) ? SCAN : IDLE;
            REQ:     state_n = WAIT;
            WAIT:    state_n = CAPTURE;
            CAPTURE: state_n = last ? IDLE : CAPTURE;
            SCAN:    state_n = (hit || last) ? IDLE : SCAN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_ff @(posedge clk)
        if (state == CAPTURE) tbl[idx] <= yx_card_position;

    always_ff @(posedge clk) begin
        if (rst) begin
            n                  <= '0;
            idx                <= '0;
            mx                 <= '0;
            my                 <= '0;
            positions_valid    <= 1'b0;
            read_all_positions <= 1'b0;
            hit_done           <= 1'b0;
            hit_found          <= 1'b0;
            hit_index          <= '0;
        end else begin
            read_all_positions <= state == IDLE && load_ok;
            hit_done           <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        n               <= num_of_cards;
                        idx             <= '0;
                        positions_valid <= 1'b0;
                    end else if (mouse_click && positions_valid) begin
                        mx  <= mouse_xpos;
                        my  <= mouse_ypos;
                        idx <= '0;
                    end
                end
                CAPTURE: begin
                    idx <= idx + 4'd1;
                    if (last) positions_valid <= 1'b1;
                end
                SCAN: begin
                    idx <= idx + 4'd1;
                    if (hit || last) begin
                        hit_done  <= 1'b1;
                        hit_found <= hit;
                        hit_index <= hit ? {1'b0, idx} : 5'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cards_hit_detect.sv
// tb_cards_hit_detect: directed checks of load timing, hit/miss scanning, arbitration and reset.
module tb_cards_hit_detect;
    logic        clk = 0, rst = 1, load_positions = 0, mouse_click = 0;
    logic [4:0]  num_of_cards = 5'd8;
    logic [19:0] yx_card_position;
    logic [9:0]  mouse_xpos = 0, mouse_ypos = 0;
    logic        read_all_positions, positions_valid, busy, hit_done, hit_found;
    logic [4:0]  hit_index;

    int n_cmp = 0, n_fail = 0;
    int rap_cnt, rap_at, vcyc, hd_cnt, dc, f, ix, busy1, rv, rb;

    logic [19:0] easy [8];
    logic [19:0] hard [16];
    logic        g_dly = 0, g_act = 0;
    int          g_i = 0;

    always #5 clk = ~clk;

    cards_hit_detect dut (
        .clk(clk), .rst(rst), .load_positions(load_positions), .num_of_cards(num_of_cards),
        .yx_card_position(yx_card_position), .read_all_positions(read_all_positions),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .mouse_click(mouse_click),
        .positions_valid(positions_valid), .busy(busy), .hit_done(hit_done),
        .hit_found(hit_found), .hit_index(hit_index)
    );

    // generator model: first word two cycles after the start pulse, all-ones when idle
    assign yx_card_position = !g_act ? '1 : (num_of_cards == 5'd16 ? hard[g_i] : easy[g_i]);
    always @(posedge clk) begin
        g_dly <= read_all_positions;
        if (g_dly) begin
            g_act <= 1;
            g_i   <= 0;
        end else if (g_act) begin
            if (g_i == int'(num_of_cards) - 1) g_act <= 0;
            g_i <= g_i + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // drive one request in cycle T, then watch cycles T+1..T+30
    task automatic run(input int ld, input int nc, input int ck, input int x, input int y,
                       input int ck_k, input int rst_k);
        @(negedge clk);
        load_positions = ld[0];
        num_of_cards   = nc[4:0];
        mouse_click    = ck[0];
        mouse_xpos     = x[9:0];
        mouse_ypos     = y[9:0];
        rap_cnt = 0; rap_at = -1; vcyc = -1; hd_cnt = 0; dc = -1; f = -1; ix = -1;
        busy1 = -1; rv = -1; rb = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (read_all_positions) begin rap_cnt++; rap_at = k; end
            if (positions_valid && vcyc < 0) vcyc = k;
            if (hit_done) begin
                hd_cnt++;
                if (dc < 0) begin dc = k; f = int'(hit_found); ix = int'(hit_index); end
            end
            if (k == 1) busy1 = int'(busy);
            if (k == rst_k + 1) begin rv = int'(positions_valid); rb = int'(busy); end
            load_positions = 0;
            mouse_click    = (k == ck_k);
            rst            = (k == rst_k);
            mouse_xpos     = 0;
            mouse_ypos     = 0;
        end
    endtask

    task automatic click(input string tag, input int nc, input int x, input int y,
                         input int ef, input int ei, input int ec);
        run(0, nc, 1, x, y, 0, 0);
        chk({tag, "_cycle"}, dc, ec);
        chk({tag, "_found"}, f, ef);
        chk({tag, "_index"}, ix, ei);
        chk({tag, "_count"}, hd_cnt, 1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) easy[i] = {10'(i < 4 ? 50 : 418), 10'(50 + 258 * (i % 4))};
        for (int i = 0; i < 16; i++) hard[i] = {10'(25 + 175 * (i / 4)), 10'(50 + 258 * (i % 4))};
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_valid", int'(positions_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rap", int'(read_all_positions), 0);
        chk("rst_done", int'(hit_done), 0);
        chk("rst_found", int'(hit_found), 0);
        chk("rst_index", int'(hit_index), 0);

        run(0, 8, 1, 60, 60, 0, 0);
        chk("click_no_load", hd_cnt, 0);
        run(1, 5, 0, 0, 0, 0, 0);
        chk("bad_count_rap", rap_cnt, 0);
        chk("bad_count_busy", busy1, 0);

        run(1, 8, 0, 0, 0, 0, 0);
        chk("easy_rap_cnt", rap_cnt, 1);
        chk("easy_rap_at", rap_at, 1);
        chk("easy_busy", busy1, 1);
        chk("easy_valid_at", vcyc, 11);

        click("e_c0", 8, 60, 60, 1, 0, 2);
        click("e_c7", 8, 830, 420, 1, 7, 9);
        click("e_miss", 8, 10, 10, 0, 0, 9);
        click("e_x249", 8, 249, 60, 1, 0, 2);
        click("e_x250", 8, 250, 60, 0, 0, 9);
        click("e_y349", 8, 60, 349, 1, 0, 2);
        click("e_y350", 8, 60, 350, 0, 0, 9);

        run(1, 8, 1, 60, 60, 0, 0);
        chk("arb_rap", rap_cnt, 1);
        chk("arb_no_done", hd_cnt, 0);
        chk("arb_valid_at", vcyc, 11);
        run(1, 8, 0, 0, 0, 4, 0);
        chk("cap_click_no_done", hd_cnt, 0);
        chk("cap_click_valid_at", vcyc, 11);

        run(1, 16, 0, 0, 0, 0, 0);
        chk("hard_valid_at", vcyc, 19);
        click("h_c15", 16, 830, 699, 1, 15, 17);
        click("h_miss", 16, 830, 700, 0, 0, 17);

        run(1, 8, 0, 0, 0, 0, 6);
        chk("rst_mid_valid", rv, 0);
        chk("rst_mid_busy", rb, 0);
        chk("rst_mid_done", hd_cnt, 0);
        chk("rst_mid_never_valid", vcyc, -1);
        run(0, 8, 1, 60, 60, 0, 0);
        chk("rst_click_ignored", hd_cnt, 0);
        run(1, 8, 0, 0, 0, 0, 0);
        chk("reload_valid_at", vcyc, 11);
        click("reload_c7", 8, 830, 420, 1, 7, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cards_hit_detect.md
# cards_hit_detect

Consumer end of the card-position stream. On request it pulses `read_all_positions` to the card position generator, captures the N streamed `{y,x}` words into a local position table, then answers mouse-click hit tests by scanning the table one card per cycle. It reports the index of the first card whose rectangle contains the cursor. It sits between the position generator and the game control logic.

## Interface

Parameters:
- `CARD_W`, 200: card width in pixels, all difficulties.
- `CARD_H_EASY`, 300: card height when N = `CARD_NUM_EASY`.
- `CARD_H_NORMAL`, 200: card height when N = `CARD_NUM_NORMAL`.
- `CARD_H_HARD`, 150: card height when N = `CARD_NUM_HARD`.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `load_positions`, in, 1: one-cycle request to (re)load the table.
- `num_of_cards`, in, `CARD_MAX_NUM_SIZE`: card count. Also wired to the generator. Held stable from the request until `positions_valid`.
- `yx_card_position`, in, `CARD_YX_POSITION_SIZE`: stream from the generator, `[19:10]` y, `[9:0]` x.
- `read_all_positions`, out, 1: registered one-cycle start pulse to the generator.
- `mouse_xpos`, `mouse_ypos`, in, 10 each: cursor position.
- `mouse_click`, in, 1: one-cycle hit-test request.
- `positions_valid`, out, 1: table holds a complete load.
- `busy`, out, 1: high in any state other than IDLE.
- `hit_done`, out, 1: one-cycle pulse when a hit test completes.
- `hit_found`, out, 1: last test hit a card. Held until the next `hit_done`.
- `hit_index`, out, `CARD_MAX_NUM_SIZE`: index of the hit card, 0 on a miss. Held until the next `hit_done`.

## Operation

- States: IDLE, REQ, WAIT, CAPTURE, SCAN.
- **IDLE**
  - `load_positions` with `num_of_cards` ∈ {EASY, NORMAL, HARD}:
    - latch N,
    - clear `positions_valid`,
    - go to REQ, with `read_all_positions` = 1 in that cycle only.
  - A load request with any other count is ignored.
  - Otherwise, `mouse_click` with `positions_valid` = 1: latch the mouse x and y, clear the scan index, go to SCAN.
  - `load_positions` has priority over a simultaneous `mouse_click`; the click is dropped.
- **REQ**: always goes to WAIT. This matches the generator's 2-cycle latency from start pulse to first word.
- **CAPTURE**
  - Each cycle, store `yx_card_position` into `table[idx]` and increment `idx`.
  - After storing `idx` = N-1: set `positions_valid`, go to IDLE.
- **SCAN**
  - Each cycle, test entry `i` = scan index.
  - Hit condition, with sums computed at 11 bits (no wrap):
    - `x >= px`,
    - `x < px + CARD_W`,
    - `y >= py`,
    - `y < py + H(N)`.
  - An entry equal to all-ones (`{1023,1023}`, the generator's idle value) never hits.
  - First hit: register `hit_found`=1, `hit_index`=i, pulse `hit_done`, go to IDLE.
  - If `i` = N-1 with no hit: register `hit_found`=0, `hit_index`=0, pulse `hit_done`, go to IDLE.
- `mouse_click` and `load_positions` are ignored whenever not in IDLE. They are not queued.
- Table entries at `idx` ≥ N are never read.

## Timing

- Reset values: state IDLE, all outputs 0, indices 0. Table contents are don't-care; with `positions_valid` = 0 they are not read.
- Load accepted in cycle T:
  - `read_all_positions` high in T+1,
  - WAIT in T+2,
  - words 0..N-1 captured in cycles T+3..T+2+N,
  - `positions_valid` = 1 and `busy` = 0 from T+3+N.
  - Easy: T+11. Hard: T+19.
- `busy` is high from T+1 through the last CAPTURE or SCAN cycle.
- Click accepted in cycle T:
  - entry `i` is compared in T+1+i,
  - a hit at `i` gives `hit_done` in T+2+i,
  - a miss gives `hit_done` in T+1+N.
- Reset mid-load or mid-scan: takes effect next edge. IDLE, `positions_valid` = 0, no `hit_done`.
- `mouse_xpos` / `mouse_ypos` changing during SCAN have no effect; the values latched at T are used.

## Test plan

- **Easy load.** Generator model, N=8, `load_positions` at T.
  - `read_all_positions` high only in T+1.
  - Table = {(50,50),(50,308),(50,566),(50,824),(418,50),(418,308),(418,566),(418,824)}.
  - `positions_valid` rises at T+11.
- **Hits, easy mode.**
  - Click (x=60, y=60) at T → `hit_done` T+2, found=1, index=0.
  - Click (x=830, y=420) at T → `hit_done` T+9, index=7.
- **Miss and edges, easy mode.**
  - Click (10,10) → `hit_done` T+9, found=0, index=0.
  - x=249, y=60 → index 0.
  - x=250 → miss.
  - y=349 hits card 0; y=350 misses.
- **Hard mode, N=16.**
  - `positions_valid` at T+19.
  - Click (830, 699) → index 15 at T+17.
  - Click (830, 700) → miss at T+17.
- **Arbitration.**
  - Load and click in the same cycle → load only, no `hit_done`.
  - Click during CAPTURE → ignored.
  - Click before any load → no `hit_done`.
  - `num_of_cards`=5 load → no `read_all_positions`.
- **Reset.**
  - `rst` in CAPTURE cycle 4 → next cycle IDLE, `positions_valid`=0, `busy`=0.
  - A subsequent click is ignored.
  - A reload completes normally.
